// File: rtl/pswitch_pkg.sv
// Shared pswitch definitions: source IDs, merge FSM encodings and the
// saturating counter increment used by the parser and merge counters.
package pswitch_pkg;

  localparam logic SRC_AGG = 1'b0;
  localparam logic SRC_BYP = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PASS_AGG = 2'd1,
    PASS_BYP = 2'd2
  } merge_state_e;

  localparam int unsigned SAT_MAX_W = 64;

  // Increment value, sticking at the all-ones pattern of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] max_v;
    max_v = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    sat_inc = (value >= max_v) ? max_v : value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage registered AXI4-Stream slice; payload held under backpressure,
// load and drain in one cycle give back-to-back beats.
module axis_out_reg #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 in_ready_c,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload
);

  assign in_ready_c = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_payload <= in_payload;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/oq_merge_arbiter.sv
// Packet-atomic round-robin 2:1 AXIS merge of the aggregator result stream and
// the parser OQ bypass stream, with per-source saturating packet counters.
module oq_merge_arbiter
  import pswitch_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned COUNT_WIDTH          = 32
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_agg_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_agg_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_agg_tuser,
  input  logic                              s_axis_agg_tvalid,
  input  logic                              s_axis_agg_tlast,
  output logic                              s_axis_agg_tready,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_byp_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_byp_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_byp_tuser,
  input  logic                              s_axis_byp_tvalid,
  input  logic                              s_axis_byp_tlast,
  output logic                              s_axis_byp_tready,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,

  input  logic                              clear_counters,
  output logic [COUNT_WIDTH-1:0]            pkt_cnt_agg,
  output logic [COUNT_WIDTH-1:0]            pkt_cnt_byp
);

  localparam int unsigned KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned PAY_W  = C_M_AXIS_DATA_WIDTH + KEEP_W + C_M_AXIS_TUSER_WIDTH + 1;

  merge_state_e     state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             slot_free_c;
  logic             agg_accept, byp_accept;
  logic [PAY_W-1:0] agg_payload, byp_payload, in_payload, out_payload;

  assign agg_payload = {s_axis_agg_tdata, s_axis_agg_tkeep, s_axis_agg_tuser, s_axis_agg_tlast};
  assign byp_payload = {s_axis_byp_tdata, s_axis_byp_tkeep, s_axis_byp_tuser, s_axis_byp_tlast};
  assign in_payload  = (state_q == PASS_BYP) ? byp_payload : agg_payload;

  assign agg_accept = s_axis_agg_tvalid & s_axis_agg_tready;
  assign byp_accept = s_axis_byp_tvalid & s_axis_byp_tready;

  // FSM state and round-robin pointer
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_BYP;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration in IDLE costs one cycle; the grant is then held to tlast.
  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    s_axis_agg_tready = 1'b0;
    s_axis_byp_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axis_agg_tvalid && s_axis_byp_tvalid) begin
          if (last_grant_q == SRC_BYP) begin
            state_d      = PASS_AGG;
            last_grant_d = SRC_AGG;
          end else begin
            state_d      = PASS_BYP;
            last_grant_d = SRC_BYP;
          end
        end else if (s_axis_agg_tvalid) begin
          state_d = PASS_AGG;
        end else if (s_axis_byp_tvalid) begin
          state_d = PASS_BYP;
        end
      end
      PASS_AGG: begin
        s_axis_agg_tready = slot_free_c;
        if (s_axis_agg_tvalid && slot_free_c && s_axis_agg_tlast) state_d = IDLE;
      end
      PASS_BYP: begin
        s_axis_byp_tready = slot_free_c;
        if (s_axis_byp_tvalid && slot_free_c && s_axis_byp_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  axis_out_reg #(
    .PAYLOAD_W (PAY_W)
  ) u_out_reg (
    .clk         (axis_aclk),
    .rst_n       (axis_resetn),
    .load        (agg_accept | byp_accept),
    .in_payload  (in_payload),
    .in_ready_c  (slot_free_c),
    .out_ready   (m_axis_tready),
    .out_valid   (m_axis_tvalid),
    .out_payload (out_payload)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_payload;

  // Packet counters: clear wins over a same-cycle end-of-packet.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      pkt_cnt_agg <= '0;
      pkt_cnt_byp <= '0;
    end else if (clear_counters) begin
      pkt_cnt_agg <= '0;
      pkt_cnt_byp <= '0;
    end else begin
      if (agg_accept && s_axis_agg_tlast)
        pkt_cnt_agg <= COUNT_WIDTH'(sat_inc(SAT_MAX_W'(pkt_cnt_agg), COUNT_WIDTH));
      if (byp_accept && s_axis_byp_tlast)
        pkt_cnt_byp <= COUNT_WIDTH'(sat_inc(SAT_MAX_W'(pkt_cnt_byp), COUNT_WIDTH));
    end
  end

endmodule
